bus_grant_arbiter: RTL and testbench

//  Round-robin arbiter that decides which datapath source drives the shared 32-bit bus.

---
 rtl/bus_grant_arbiter_pkg.sv | 23 ++
 rtl/bus_grant_arbiter_rr_pick.sv | 41 ++++
 rtl/bus_grant_arbiter.sv | 112 +++++++++++
 tb/tb_bus_grant_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_grant_arbiter_pkg.sv
// Source-number constants and FSM encoding shared by the bus grant arbiter,
// the bus source encoder and the bus multiplexer.
package bus_grant_arbiter_pkg;

  localparam int         BUS_SRC_MAX   = 24;
  localparam logic [4:0] BUS_IDLE_CODE = 5'd31;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Ones in the positions of sources that actually exist.
  function automatic logic [BUS_SRC_MAX-1:0] src_mask(input int n);
    logic [BUS_SRC_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < BUS_SRC_MAX; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Combinational round-robin pick: first candidate at or above i_ptr, wrapping
// at NUM_SRC-1, ignoring sources set in i_excl.
module bus_grant_arbiter_rr_pick
  import bus_grant_arbiter_pkg::*;
#(
  parameter int NUM_SRC = BUS_SRC_MAX
) (
  input  logic [BUS_SRC_MAX-1:0] i_req,
  input  logic [4:0]             i_ptr,
  input  logic [BUS_SRC_MAX-1:0] i_excl,
  output logic [BUS_SRC_MAX-1:0] o_onehot,
  output logic [4:0]             o_idx,
  output logic                   o_found
);

  localparam logic [4:0] LAST = 5'(NUM_SRC - 1);

  logic [BUS_SRC_MAX-1:0] w_cand;
  logic [4:0]             w_pos;

  assign w_cand = i_req & ~i_excl & src_mask(NUM_SRC);

  // Walk the ring from the pointer; the idle code is the no-winner image.
  always_comb begin
    o_onehot = '0;
    o_idx    = BUS_IDLE_CODE;
    o_found  = 1'b0;
    w_pos    = i_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!o_found && w_cand[w_pos]) begin
        o_found         = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end else begin
        o_found = o_found;
      end
      w_pos = (w_pos == LAST) ? 5'd0 : w_pos + 5'd1;
    end
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus owner selection with bounded hold; produces the registered
// one-hot grant word and its encoder image for the shared 32-bit bus.
module bus_grant_arbiter
  import bus_grant_arbiter_pkg::*;
#(
  parameter int NUM_SRC  = 24,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic        i_clock,
  input  logic        i_clear_n,
  input  logic [23:0] i_req,
  output logic [31:0] o_grant,
  output logic        o_grant_valid,
  output logic [4:0]  o_grant_idx,
  output logic        o_preempt
);

  localparam logic [4:0]       LAST       = 5'(NUM_SRC - 1);
  localparam logic             PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_SAT   = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t                 r_state;
  logic [BUS_SRC_MAX-1:0] r_grant;
  logic [4:0]             r_idx;
  logic [4:0]             r_ptr;
  logic                   r_valid;
  logic                   r_preempt;
  logic [CNT_W-1:0]       r_hold;

  logic [BUS_SRC_MAX-1:0] w_req;
  logic [BUS_SRC_MAX-1:0] w_excl;
  logic [BUS_SRC_MAX-1:0] w_win;
  logic [4:0]             w_win_idx;
  logic [4:0]             w_pick_ptr;
  logic [4:0]             w_next_ptr;
  logic                   w_found;
  logic                   w_own_req;
  logic                   w_timeout;

  assign w_req      = i_req & src_mask(NUM_SRC);
  assign w_own_req  = |(w_req & r_grant);
  assign w_next_ptr = (r_idx == LAST) ? 5'd0 : r_idx + 5'd1;
  // While owned, the search starts past the owner and skips it.
  assign w_pick_ptr = (r_state == ST_GRANT) ? w_next_ptr : r_ptr;
  assign w_excl     = (r_state == ST_GRANT) ? r_grant : '0;
  assign w_timeout  = PREEMPT_EN && (r_hold == HOLD_SAT) && w_found;

  bus_grant_arbiter_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .i_req    (w_req),
    .i_ptr    (w_pick_ptr),
    .i_excl   (w_excl),
    .o_onehot (w_win),
    .o_idx    (w_win_idx),
    .o_found  (w_found)
  );

  // Ownership FSM, rotation pointer, hold counter and output registers.
  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_idx     <= BUS_IDLE_CODE;
      r_preempt <= 1'b0;
      r_ptr     <= 5'd0;
      r_hold    <= '0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_grant <= w_win;
            r_valid <= 1'b1;
            r_idx   <= w_win_idx;
            r_hold  <= '0;
          end
        end
        ST_GRANT: begin
          if (!w_own_req || w_timeout) begin
            // Release or forced handover; an empty pick yields grant 0 / idle code.
            r_ptr     <= w_next_ptr;
            r_preempt <= w_own_req;
            r_grant   <= w_win;
            r_valid   <= w_found;
            r_idx     <= w_win_idx;
            r_hold    <= '0;
            r_state   <= w_found ? ST_GRANT : ST_IDLE;
          end else if (r_hold != HOLD_SAT) begin
            r_hold <= r_hold + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_valid <= 1'b0;
          r_idx   <= BUS_IDLE_CODE;
          r_hold  <= '0;
        end
      endcase
    end
  end

  assign o_grant       = {{(32 - BUS_SRC_MAX){1'b0}}, r_grant};
  assign o_grant_valid = r_valid;
  assign o_grant_idx   = r_idx;
  assign o_preempt     = r_preempt;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Scoreboard bench for bus_grant_arbiter (MAX_HOLD=4): each step pushes the
// expected post-edge outputs, then pops and compares them after the edge.
module tb_bus_grant_arbiter;

  localparam int NUM_SRC    = 24;
  localparam int MAX_HOLD   = 4;
  localparam int CNT_W      = 4;
  localparam int WAIT_BOUND = (NUM_SRC - 1) * MAX_HOLD + 1;

  typedef struct packed {
    logic [23:0] req;
    logic        clr_n;
    logic [31:0] eg;
    logic        ep;
  } step_t;

  typedef struct {
    logic [38:0] vec;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear_n;
  logic [23:0] req;
  logic [31:0] grant;
  logic        gv;
  logic [4:0]  gidx;
  logic        pre;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  exp_t sbq[$];
  int   wait_cnt [NUM_SRC];

  always #5 clk = ~clk;

  bus_grant_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clock       (clk),
    .i_clear_n     (clear_n),
    .i_req         (req),
    .o_grant       (grant),
    .o_grant_valid (gv),
    .o_grant_idx   (gidx),
    .o_preempt     (pre)
  );

  function automatic logic [4:0] enc(input logic [31:0] g);
    logic [4:0] k;
    k = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (g[i]) k = 5'(i);
    end
    return k;
  endfunction

  // Expected {grant, valid, idx, preempt} derived from an expected grant word.
  function automatic logic [38:0] pack_exp(input logic [31:0] g, input logic p);
    return {g, (g != 32'd0), enc(g), p};
  endfunction

  task automatic drv(input step_t s, input string tag);
    exp_t e;
    req     = s.req;
    clear_n = s.clr_n;
    e.vec   = pack_exp(s.eg, s.ep);
    e.tag   = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants and starvation bound, sampled mid-cycle.
  always @(negedge clk) begin
    int worst;
    if (mon_en) begin
      worst = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (clear_n === 1'b1 && req[i] && !grant[i]) wait_cnt[i] = wait_cnt[i] + 1;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      n_checks++;
      if (!$onehot0(grant) || grant[31:24] !== 8'h00 || gidx !== enc(grant) || gv !== (grant != 32'd0)) begin
        n_errors++;
        $display("FAIL invariant @%0t: got grant=%h valid=%b idx=%0d required onehot0, top=0, idx=%0d", $time, grant, gv, gidx, enc(grant));
      end
      n_checks++;
      if (worst > WAIT_BOUND) begin
        n_errors++;
        $display("FAIL starvation @%0t: got wait %0d required <= %0d", $time, worst, WAIT_BOUND);
      end
    end
  end

  task automatic test_reset();
    step_t plan[$];
    exp_t  e;
    plan.push_back(step_t'{24'hFFFFFF, 1'b0, 32'h0, 1'b0});
    plan.push_back(step_t'{24'hFFFFFF, 1'b0, 32'h0, 1'b0});
    foreach (plan[i]) begin
      drv(plan[i], "reset");
      e = sbq.pop_front();
      n_checks++;
      if ({grant, gv, gidx, pre} !== e.vec) begin
        n_errors++;
        $display("FAIL %s step %0d: got %h required %h", e.tag, i, {grant, gv, gidx, pre}, e.vec);
      end
    end
  endtask

  task automatic test_single();
    step_t plan[$];
    exp_t  e;
    plan.push_back(step_t'{24'h000020, 1'b1, 32'h20, 1'b0});
    plan.push_back(step_t'{24'h000020, 1'b1, 32'h20, 1'b0});
    plan.push_back(step_t'{24'h000000, 1'b1, 32'h0, 1'b0});
    plan.push_back(step_t'{24'h000000, 1'b1, 32'h0, 1'b0});
    foreach (plan[i]) begin
      drv(plan[i], "single");
      e = sbq.pop_front();
      n_checks++;
      if ({grant, gv, gidx, pre} !== e.vec) begin
        n_errors++;
        $display("FAIL %s step %0d: got %h required %h", e.tag, i, {grant, gv, gidx, pre}, e.vec);
      end
    end
  endtask

  task automatic test_rotation();
    step_t plan[$];
    exp_t  e;
    plan.push_back(step_t'{24'h000204, 1'b0, 32'h0, 1'b0});
    for (int k = 0; k < MAX_HOLD; k++) plan.push_back(step_t'{24'h000204, 1'b1, 32'h4, 1'b0});
    plan.push_back(step_t'{24'h000204, 1'b1, 32'h200, 1'b1});
    for (int k = 1; k < MAX_HOLD; k++) plan.push_back(step_t'{24'h000204, 1'b1, 32'h200, 1'b0});
    plan.push_back(step_t'{24'h000204, 1'b1, 32'h4, 1'b1});
    plan.push_back(step_t'{24'h000000, 1'b1, 32'h0, 1'b0});
    foreach (plan[i]) begin
      drv(plan[i], "rotation");
      e = sbq.pop_front();
      n_checks++;
      if ({grant, gv, gidx, pre} !== e.vec) begin
        n_errors++;
        $display("FAIL %s step %0d: got %h required %h", e.tag, i, {grant, gv, gidx, pre}, e.vec);
      end
    end
  endtask

  task automatic test_saturate();
    step_t plan[$];
    exp_t  e;
    plan.push_back(step_t'{24'h000000, 1'b0, 32'h0, 1'b0});
    for (int k = 0; k < 6; k++) plan.push_back(step_t'{24'h000004, 1'b1, 32'h4, 1'b0});
    plan.push_back(step_t'{24'h000204, 1'b1, 32'h200, 1'b1});
    plan.push_back(step_t'{24'h000000, 1'b1, 32'h0, 1'b0});
    foreach (plan[i]) begin
      drv(plan[i], "saturate");
      e = sbq.pop_front();
      n_checks++;
      if ({grant, gv, gidx, pre} !== e.vec) begin
        n_errors++;
        $display("FAIL %s step %0d: got %h required %h", e.tag, i, {grant, gv, gidx, pre}, e.vec);
      end
    end
  endtask

  task automatic test_wrap();
    step_t plan[$];
    exp_t  e;
    plan.push_back(step_t'{24'h000000, 1'b0, 32'h0, 1'b0});
    plan.push_back(step_t'{24'h800000, 1'b1, 32'h800000, 1'b0});
    plan.push_back(step_t'{24'h000003, 1'b1, 32'h1, 1'b0});
    plan.push_back(step_t'{24'h000003, 1'b1, 32'h1, 1'b0});
    plan.push_back(step_t'{24'h000000, 1'b1, 32'h0, 1'b0});
    foreach (plan[i]) begin
      drv(plan[i], "wrap");
      e = sbq.pop_front();
      n_checks++;
      if ({grant, gv, gidx, pre} !== e.vec) begin
        n_errors++;
        $display("FAIL %s step %0d: got %h required %h", e.tag, i, {grant, gv, gidx, pre}, e.vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t plan[$];
    exp_t  e;
    plan.push_back(step_t'{24'h000000, 1'b0, 32'h0, 1'b0});
    plan.push_back(step_t'{24'h000008, 1'b1, 32'h8, 1'b0});
    plan.push_back(step_t'{24'h000080, 1'b1, 32'h80, 1'b0});
    plan.push_back(step_t'{24'h000080, 1'b1, 32'h80, 1'b0});
    plan.push_back(step_t'{24'h000000, 1'b1, 32'h0, 1'b0});
    foreach (plan[i]) begin
      drv(plan[i], "back_to_back");
      e = sbq.pop_front();
      n_checks++;
      if ({grant, gv, gidx, pre} !== e.vec) begin
        n_errors++;
        $display("FAIL %s step %0d: got %h required %h", e.tag, i, {grant, gv, gidx, pre}, e.vec);
      end
    end
  endtask

  // Pointer is moved to 10 first so a pointer that survives reset would pick 20.
  task automatic test_midop_reset();
    step_t plan[$];
    exp_t  e;
    plan.push_back(step_t'{24'h000000, 1'b0, 32'h0, 1'b0});
    plan.push_back(step_t'{24'h000200, 1'b1, 32'h200, 1'b0});
    plan.push_back(step_t'{24'h000000, 1'b1, 32'h0, 1'b0});
    plan.push_back(step_t'{24'h001000, 1'b1, 32'h1000, 1'b0});
    plan.push_back(step_t'{24'h001000, 1'b1, 32'h1000, 1'b0});
    plan.push_back(step_t'{24'h001000, 1'b0, 32'h0, 1'b0});
    plan.push_back(step_t'{24'h100020, 1'b1, 32'h20, 1'b0});
    plan.push_back(step_t'{24'h000000, 1'b1, 32'h0, 1'b0});
    foreach (plan[i]) begin
      drv(plan[i], "midop_reset");
      e = sbq.pop_front();
      n_checks++;
      if ({grant, gv, gidx, pre} !== e.vec) begin
        n_errors++;
        $display("FAIL %s step %0d: got %h required %h", e.tag, i, {grant, gv, gidx, pre}, e.vec);
      end
    end
  endtask

  initial begin
    req     = 24'h0;
    clear_n = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_single();
    test_rotation();
    test_saturate();
    test_wrap();
    test_back_to_back();
    test_midop_reset();
    n_checks++;
    if (sbq.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
